// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the tiled GEMM/conv pass sequencer.
package conv_seq_pkg;

  localparam int ARRAY_W_DEF = 8;
  localparam int FLUSH_LEN   = 2 * ARRAY_W_DEF - 1;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    WLATCH,
    STREAM,
    DRAIN,
    DONE,
    BUSY_DEGEN
  } seq_state_e;

  // Cycles between the first activation row entering the skewed array and
  // the first valid accumulator output.
  function automatic int flush_len(input int array_w);
    return 2 * array_w - 1;
  endfunction

endpackage

// File: rtl/tile_loop_counter.sv
// Up-counter with a captured limit; holds at limit-1 and flags it as last.
module tile_loop_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] lim_q;

  // NOTE: async active-low reset in the sensitivity list, and only
  // non-blocking assignments for state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      lim_q <= '0;
    end else if (load) begin
      count <= '0;
      lim_q <= limit;
    end else if (clear) begin
      count <= '0;
    end else if (en && !last) begin
      count <= count + W'(1);
    end
  end

  assign last = (count == lim_q - W'(1));

endmodule

// File: rtl/conv_tile_sequencer.sv
// Sequences weight load, latch, activation stream and drain for each K tile
// and column tile of one weight-stationary pass on the systolic array.
module conv_tile_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ARRAY_W = ARRAY_W_DEF,
  parameter int KT_W    = 5,
  parameter int NT_W    = 11,
  parameter int MR_W    = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KT_W-1:0] cfg_k_tiles,
  input  logic [NT_W-1:0] cfg_n_tiles,
  input  logic [MR_W-1:0] cfg_m_rows,
  input  logic            out_stall,
  output logic            busy,
  output logic            done,
  output logic            weight_buffer_load_en,
  output logic            write_weight_en,
  output logic            input_buffer_out_en,
  output logic            input_buffer_delay_clear,
  output logic            output_buffer_acc_clear,
  output logic            output_buffer_acc_en,
  output logic            output_buffer_out_en,
  output logic            tile_weight_next_row_en,
  output logic            tile_input_next_col_en,
  output logic [NT_W-1:0] tile_col_idx,
  output logic [KT_W-1:0] inner_loop_idx
);

  localparam int FLUSH = flush_len(ARRAY_W);
  localparam int AW_B  = $clog2(2 * ARRAY_W);
  // Wide enough for m_rows + FLUSH without overflow.
  localparam int CW    = ((MR_W > AW_B) ? MR_W : AW_B) + 1;

  seq_state_e state, state_nxt;
  logic [MR_W-1:0] m_q;

  logic [CW-1:0] ph_cnt, ph_limit, win_len;
  logic          ph_load, ph_en, ph_last;
  logic          k_load, k_clear, k_en, k_last;
  logic          n_load, n_clear, n_en, n_last;

  logic accept, degen, stream_end, drain_fire, drain_end;

  assign accept     = (state == IDLE) && start;
  assign degen      = (cfg_k_tiles == '0) || (cfg_n_tiles == '0) || (cfg_m_rows == '0);
  assign stream_end = (state == STREAM) && ph_last;
  assign drain_fire = (state == DRAIN) && !out_stall;
  assign drain_end  = drain_fire && ph_last;
  assign win_len    = CW'(m_q) + CW'(FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      m_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) m_q <= cfg_m_rows;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (start) state_nxt = degen ? BUSY_DEGEN : WLOAD;
      WLOAD:      if (ph_last) state_nxt = WLATCH;
      WLATCH:     state_nxt = STREAM;
      STREAM:     if (ph_last) state_nxt = k_last ? DRAIN : WLOAD;
      DRAIN:      if (drain_end) state_nxt = n_last ? DONE : WLOAD;
      DONE:       state_nxt = IDLE;
      BUSY_DEGEN: state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // One phase counter serves the load, stream-window and drain-row counts;
  // it is reloaded with the next phase's length on each transition.
  always_comb begin
    ph_load  = 1'b0;
    ph_en    = 1'b0;
    ph_limit = CW'(ARRAY_W);
    unique case (state)
      IDLE:   ph_load = start;
      WLOAD:  ph_en = 1'b1;
      WLATCH: begin
        ph_load  = 1'b1;
        ph_limit = win_len;
      end
      STREAM: begin
        ph_en = 1'b1;
        if (ph_last) begin
          ph_load  = 1'b1;
          ph_limit = k_last ? CW'(m_q) : CW'(ARRAY_W);
        end
      end
      DRAIN: begin
        ph_en   = drain_fire;
        ph_load = drain_end;
      end
      default: ;
    endcase
  end

  assign k_load  = accept;
  assign k_clear = drain_end;
  assign k_en    = stream_end && !k_last;
  assign n_load  = accept;
  assign n_clear = (state == DONE);
  assign n_en    = drain_end && !n_last;

  tile_loop_counter #(.W(CW)) u_phase_cnt (
    .clk(clk), .rst(rst), .load(ph_load), .clear(1'b0), .en(ph_en),
    .limit(ph_limit), .count(ph_cnt), .last(ph_last)
  );

  tile_loop_counter #(.W(KT_W)) u_inner_cnt (
    .clk(clk), .rst(rst), .load(k_load), .clear(k_clear), .en(k_en),
    .limit(cfg_k_tiles), .count(inner_loop_idx), .last(k_last)
  );

  tile_loop_counter #(.W(NT_W)) u_col_cnt (
    .clk(clk), .rst(rst), .load(n_load), .clear(n_clear), .en(n_en),
    .limit(cfg_n_tiles), .count(tile_col_idx), .last(n_last)
  );

  assign busy                     = (state != IDLE);
  assign done                     = (state == DONE);
  assign weight_buffer_load_en    = (state == WLOAD);
  assign write_weight_en          = (state == WLATCH);
  assign input_buffer_delay_clear = (state == WLATCH);
  assign output_buffer_acc_clear  = (state == WLATCH) && (inner_loop_idx == '0);
  assign input_buffer_out_en      = (state == STREAM) && (ph_cnt < CW'(m_q));
  assign output_buffer_acc_en     = (state == STREAM) && (ph_cnt >= CW'(FLUSH));
  assign output_buffer_out_en     = drain_fire;
  assign tile_weight_next_row_en  = stream_end && !k_last;
  assign tile_input_next_col_en   = drain_end;

endmodule
